// File: rtl/uart_rx_handler.sv
// uart_rx_handler: buffers single-cycle byte strobes from the UART RX PHY in a
// circular FIFO and presents them on an AXI-Stream master port. Bytes that
// arrive with a framing error, or while the FIFO is full and not draining,
// are dropped and counted in saturating statistics counters.
module uart_rx_handler #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_byte_valid,
   input  logic [7:0]                    rx_byte_data,
   input  logic                          rx_frame_err,
   output logic [7:0]                    m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow_sticky,
   output logic [CNT_W-1:0]              overflow_cnt,
   output logic [CNT_W-1:0]              frame_err_cnt,
   input  logic                          clear_stats
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_next;
   logic             tvalid_q;
   logic             full;
   logic             push;
   logic             pop;
   logic             frame_evt;
   logic             ovf_evt;

   // Saturating increment with clear; an event in the clear cycle leaves the count at 1.
   function automatic logic [CNT_W-1:0] stat_next(input logic [CNT_W-1:0] cnt,
                                                   input logic             evt,
                                                   input logic             clr);
      logic [CNT_W-1:0] base;
      base = clr ? '0 : cnt;
      if (evt && (base != '1)) begin
         return base + 1'b1;
      end
      return base;
   endfunction

   // Handshake decode and next occupancy; a frame error outranks the full check.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      level_next = level_q;
      full       = (level_q == FULL_LEVEL);
      pop        = tvalid_q & m_axis_tready;
      frame_evt  = rx_byte_valid & rx_frame_err;
      push       = rx_byte_valid & ~rx_frame_err & (~full | pop);
      ovf_evt    = rx_byte_valid & ~rx_frame_err & full & ~pop;
      case ({push, pop})
         2'b10:   level_next = level_q + 1'b1;
         2'b01:   level_next = level_q - 1'b1;
         default: level_next = level_q;
      endcase
   end

   // Byte storage; written only on an accepted push.
   // NOTE: storage has no reset: its contents are don't-care until the level says otherwise.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_byte_data;
      end
   end

   // Pointers, occupancy and the registered tvalid that tracks it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_q  <= '0;
         tvalid_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level_q  <= level_next;
         tvalid_q <= (level_next != '0);
      end
   end

   // Drop statistics: saturating counters plus the overflow sticky bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt    <= '0;
         frame_err_cnt   <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         overflow_cnt    <= stat_next(overflow_cnt, ovf_evt, clear_stats);
         frame_err_cnt   <= stat_next(frame_err_cnt, frame_evt, clear_stats);
         overflow_sticky <= ovf_evt | (overflow_sticky & ~clear_stats);
      end
   end

   assign m_axis_tdata  = mem[rd_ptr];
   assign m_axis_tvalid = tvalid_q;
   assign fifo_level    = level_q;

endmodule

// File: tb/tb_uart_rx_handler.sv
// Testbench for uart_rx_handler: a table of single-cycle vectors with expected
// level/tvalid, hand-written multi-cycle sequences, and a byte scoreboard fed
// by a small reference model of acceptance, drops and counters.
module tb_uart_rx_handler;

   localparam int DEPTH = 16;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic             clk;
   logic             rst_n;
   logic             rx_byte_valid;
   logic [7:0]       rx_byte_data;
   logic             rx_frame_err;
   logic [7:0]       m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic [4:0]       fifo_level;
   logic             overflow_sticky;
   logic [CW-1:0]    overflow_cnt;
   logic [CW-1:0]    frame_err_cnt;
   logic             clear_stats;

   uart_rx_handler #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_byte_valid   (rx_byte_valid),
      .rx_byte_data    (rx_byte_data),
      .rx_frame_err    (rx_frame_err),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .fifo_level      (fifo_level),
      .overflow_sticky (overflow_sticky),
      .overflow_cnt    (overflow_cnt),
      .frame_err_cnt   (frame_err_cnt),
      .clear_stats     (clear_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] sb [$];
   int m_level  = 0;
   int m_ov     = 0;
   int m_fe     = 0;
   int m_sticky = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       fe;
      logic       rdy;
      logic       clr;
      int         exp_level;
      logic       exp_tvalid;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, check outputs against the model at the
   // negedge, update the model, then return at posedge+1.
   task automatic step(input logic v, input logic [7:0] d, input logic fe,
                       input logic rdy, input logic clr);
      logic pop;
      logic full;
      rx_byte_valid = v;
      rx_byte_data  = d;
      rx_frame_err  = fe;
      m_axis_tready = rdy;
      clear_stats   = clr;
      @(negedge clk);
      check("tvalid", 32'(m_axis_tvalid), 32'(m_level != 0));
      check("level", 32'(fifo_level), 32'(m_level));
      if (m_level != 0) check("tdata", 32'(m_axis_tdata), 32'(sb[0]));
      check("ovf_cnt", 32'(overflow_cnt), 32'(m_ov));
      check("ovf_sticky", 32'(overflow_sticky), 32'(m_sticky));
      check("fe_cnt", 32'(frame_err_cnt), 32'(m_fe));
      pop  = (m_level != 0) && rdy;
      full = (m_level == DEPTH);
      if (clr) begin
         m_ov = 0;
         m_fe = 0;
         m_sticky = 0;
      end
      if (v && fe) begin
         if (m_fe < CMAX) m_fe++;
      end else if (v && (!full || pop)) begin
         sb.push_back(d);
         m_level++;
      end else if (v) begin
         if (m_ov < CMAX) m_ov++;
         m_sticky = 1;
      end
      if (pop) begin
         void'(sb.pop_front());
         m_level--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH && m_level != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("drained_tvalid", 32'(m_axis_tvalid), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[2]  = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[4]  = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 0, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[8]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[10] = '{1'b1, 8'h70, 1'b0, 1'b0, 1'b0, 1, 1'b1};
      tbl[11] = '{1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 2, 1'b1};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};

      rst_n = 1'b0;
      rx_byte_valid = 1'b0;
      rx_byte_data  = 8'h00;
      rx_frame_err  = 1'b0;
      m_axis_tready = 1'b0;
      clear_stats   = 1'b0;
      #8;
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ovf_cnt", 32'(overflow_cnt), 32'd0);
      check("rst_sticky", 32'(overflow_sticky), 32'd0);
      check("rst_fe_cnt", 32'(frame_err_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // pass-through, framing error and back-to-back strobes
      for (int i = 0; i < NV; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].fe, tbl[i].rdy, tbl[i].clr);
         check("tbl_level", 32'(fifo_level), 32'(tbl[i].exp_level));
         check("tbl_tvalid", 32'(m_axis_tvalid), 32'(tbl[i].exp_tvalid));
      end
      check("tbl_fe_cnt", 32'(frame_err_cnt), 32'd1);

      // fill with 19 bytes while stalled
      for (int i = 0; i < 19; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check("fill_level", 32'(fifo_level), 32'd16);
      check("fill_ovf_cnt", 32'(overflow_cnt), 32'd3);
      check("fill_sticky", 32'(overflow_sticky), 32'd1);
      check("fill_head", 32'(m_axis_tdata), 32'h00);

      // clear stats, then full with simultaneous pop accepts 0xAA
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("clr_ovf_cnt", 32'(overflow_cnt), 32'd0);
      check("clr_sticky", 32'(overflow_sticky), 32'd0);
      check("clr_fe_cnt", 32'(frame_err_cnt), 32'd0);
      check("clr_level", 32'(fifo_level), 32'd16);
      step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
      check("fullpop_level", 32'(fifo_level), 32'd16);
      check("fullpop_ovf_cnt", 32'(overflow_cnt), 32'd0);
      check("fullpop_head", 32'(m_axis_tdata), 32'h01);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("aa_head", 32'(m_axis_tdata), 32'hAA);
      check("aa_level", 32'(fifo_level), 32'd1);
      drain();

      // error event coinciding with clear_stats, then counter saturation
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      check("clrevt_ovf_cnt", 32'(overflow_cnt), 32'd1);
      check("clrevt_sticky", 32'(overflow_sticky), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
      check("sat_ovf_cnt", 32'(overflow_cnt), 32'd3);
      step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      check("clrfe_fe_cnt", 32'(frame_err_cnt), 32'd1);
      check("clrfe_ovf_cnt", 32'(overflow_cnt), 32'd0);
      check("clrfe_level", 32'(fifo_level), 32'd16);
      drain();

      // 40 bytes through with random valid/tready, across pointer wrap
      begin
         int sent = 0;
         for (int i = 0; i < 400 && sent < 40; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, 8'(8'h80 + sent), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (v) sent++;
         end
         check("rand_sent", 32'(sent), 32'd40);
      end
      drain();

      // asynchronous reset mid-cycle with bytes buffered
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("arst_level", 32'(fifo_level), 32'd0);
      sb.delete();
      m_level = 0;
      m_ov = 0;
      m_fe = 0;
      m_sticky = 0;
      #1 rst_n = 1'b1;
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      check("post_rst_level", 32'(fifo_level), 32'd1);
      check("post_rst_tdata", 32'(m_axis_tdata), 32'h99);
      check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_handler.md
Name: uart_rx_handler

Overview:
Receive-side companion to the UART TX path. It takes single-cycle byte strobes from the UART RX PHY and buffers them in a small circular FIFO. Bytes leave on an AXI-Stream master port toward the order/command parser. It absorbs downstream backpressure, drops and counts bytes that arrive with framing errors or while the FIFO is full, and exposes FIFO level and error statistics.

Parameters:
FIFO_DEPTH, 16, number of byte entries; power of two, 2 to 256
CNT_W, 16, width of the saturating error counters

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
rx_byte_valid  input  1  PHY strobe: one-cycle pulse per received byte
rx_byte_data  input  8  PHY byte; qualified by rx_byte_valid
rx_frame_err  input  1  PHY stop-bit error; qualified by rx_byte_valid
m_axis_tdata  output  8  byte at FIFO head
m_axis_tvalid  output  1  FIFO non-empty
m_axis_tready  input  1  downstream accept
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
overflow_sticky  output  1  set on any drop caused by a full FIFO
overflow_cnt  output  CNT_W  saturating count of bytes dropped because the FIFO was full
frame_err_cnt  output  CNT_W  saturating count of bytes dropped because of a framing error
clear_stats  input  1  synchronous clear of overflow_sticky, overflow_cnt and frame_err_cnt

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers = 0, fifo_level = 0, m_axis_tvalid = 0, overflow_sticky = 0, both counters = 0. Storage contents are don't-care. m_axis_tdata is don't-care while tvalid = 0.
- Reset asserted mid-operation: all buffered bytes are discarded immediately. An rx_byte_valid present in the cycle reset releases is accepted normally.
- push = rx_byte_valid & !rx_frame_err & (!full | pop).
- pop = m_axis_tvalid & m_axis_tready.
- full: fifo_level == FIFO_DEPTH.
- Write: on push, mem[wr_ptr] <= rx_byte_data and wr_ptr advances by 1.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH with no special case at the wrap point.
- Read: m_axis_tdata = mem[rd_ptr] (first-word fall-through). On pop, rd_ptr advances by 1.
- m_axis_tvalid = (fifo_level != 0), registered with the level.
- Latency: a byte strobed into an empty FIFO at edge N gives m_axis_tvalid = 1 with that byte after edge N (one cycle).
- AXI rule: once tvalid = 1, tdata holds stable until pop. tvalid never deasserts without a pop.
- Level update each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: the incoming byte is accepted and the level stays FIFO_DEPTH.
- Empty: pop is impossible. A push makes tvalid rise the next cycle; there is no same-cycle bypass.
- Framing error: when rx_byte_valid = 1 and rx_frame_err = 1, the byte is never written and frame_err_cnt increments. This takes precedence over the full check, so overflow_cnt does not increment for that byte.
- Overflow: when rx_byte_valid = 1, rx_frame_err = 0, full = 1 and pop = 0:
  - the byte is dropped;
  - overflow_cnt increments;
  - overflow_sticky is set.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_stats: on the next edge, the counters go to 0 and overflow_sticky goes to 0.
- An error event in the same cycle as clear_stats leaves the counter at 1 and the sticky at 1 (the event wins over the clear).
- FIFO contents, pointers and fifo_level are unaffected by clear_stats.
- rx_byte_valid held high for consecutive cycles is legal: each cycle is treated as a separate byte.

Test Plan:
- Basic pass-through: tready = 1, strobe 0x41, 0x42, 0x43 on alternate cycles -> each byte appears on tdata with tvalid one cycle after its strobe; fifo_level peaks at 1; in-order delivery.
- Fill and overflow: FIFO_DEPTH = 16, tready = 0, push 0x00..0x12 (19 bytes) -> fifo_level = 16, overflow_cnt = 3, overflow_sticky = 1. Releasing tready drains 0x00..0x0F in order, then tvalid = 0.
- Full plus simultaneous pop: FIFO full, tready = 1 for one cycle while 0xAA is strobed -> level stays 16, overflow_cnt unchanged, 0xAA is delivered as the 17th byte overall.
- Framing error: strobe 0x55 with rx_frame_err = 1, then 0x66 clean -> only 0x66 is output, frame_err_cnt = 1, level maximum 1.
- Wrap and saturation: CNT_W = 2, 40 bytes through with random tready -> data order preserved across pointer wrap. Five overflow events -> overflow_cnt = 3.
- Reset and clear: with 5 bytes buffered, pulse rst_n low asynchronously mid-cycle -> tvalid = 0 and level = 0 immediately. Separately, clear_stats together with an overflow event -> overflow_cnt = 1, overflow_sticky = 1.
